// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Bus between the alu_sequencer controller and its surroundings (program ROM,
// ALU datapath and the carry register).
//   prog_addr  : program ROM address (sequencer -> ROM)
//   prog_data  : ROM read data, one cycle after prog_addr (ROM -> sequencer)
//   cy         : registered carry flag from CY_reg (datapath -> sequencer)
//   alu_op     : ALU operation code
//   alu_ci     : ALU carry-in
//   b_sel      : B-operand mux select (0 = register file, 1 = imm)
//   reg_sel    : register-file index for operand B
//   imm        : latched immediate / operand byte
//   acc_we     : accumulator write strobe
//   cy_ce      : carry register clock enable
//   halt       : high while the sequencer is halted
// The master modport is the sequencer view, the slave modport the
// ROM/datapath view.
// ---------------------------------------------------------------------------
interface alu_sequencer_if;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic       cy;
  logic [2:0] alu_op;
  logic       alu_ci;
  logic       b_sel;
  logic [1:0] reg_sel;
  logic [7:0] imm;
  logic       acc_we;
  logic       cy_ce;
  logic       halt;

  modport master (
    output prog_addr, alu_op, alu_ci, b_sel, reg_sel, imm, acc_we, cy_ce, halt,
    input  prog_data, cy
  );

  modport slave (
    input  prog_addr, alu_op, alu_ci, b_sel, reg_sel, imm, acc_we, cy_ce, halt,
    output prog_data, cy
  );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle fetch/decode/execute controller for an 8-bit ALU and its carry
// register. Instruction bytes come from a synchronous program ROM (data valid
// one cycle after the address). Each instruction is decoded into ALU control
// signals; conditional and unconditional jumps use the registered carry.
//
// Instruction classes (IR[7:6]):
//   00 ooo c rr : ALU op with register operand        (1 byte)
//   01 ooo c xx : ALU op with immediate operand        (2 bytes)
//   10 jj xxxx  : JMP / JC / JNC / 2-byte NOP, target  (2 bytes)
//   11          : 0xFF = HLT, anything else 1-byte NOP
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : alu_sequencer_if.master (ROM address/data, carry in, ALU controls)
// ---------------------------------------------------------------------------
module alu_sequencer (
  input  logic             clk,
  input  logic             rst,
  alu_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  state_e     state_q;
  logic [7:0] pc_q;
  logic [7:0] ir_q;
  logic [7:0] imm_q;
  logic       acc_we_q;
  logic       cy_ce_q;
  logic       halt_q;

  // Decode of the byte arriving from the ROM during DECODE.
  logic       dec_two_byte_s;
  logic       dec_alu_reg_s;
  logic       dec_halt_s;
  logic       dec_cy_ce_s;
  // Decode of the latched IR during OPERAND.
  logic       ir_alu_imm_s;
  logic       ir_cy_ce_s;
  logic       jump_taken_s;
  logic       alu_ci_s;

  // Classify the incoming instruction byte while in DECODE.
  always_comb begin
    dec_two_byte_s = (bus.prog_data[7:6] == 2'b01) || (bus.prog_data[7:6] == 2'b10);
    dec_alu_reg_s  = (bus.prog_data[7:6] == 2'b00);
    dec_halt_s     = (bus.prog_data == 8'hFF);
    // Ops 110 and 111 do not update the carry register.
    dec_cy_ce_s    = (bus.prog_data[5:3] <= 3'b101);
  end

  // Classify the latched instruction and evaluate the jump condition on cy.
  always_comb begin
    ir_alu_imm_s = (ir_q[7:6] == 2'b01);
    ir_cy_ce_s   = (ir_q[5:3] <= 3'b101);
    case (ir_q[5:4])
      2'b00:   jump_taken_s = 1'b1;       // JMP
      2'b01:   jump_taken_s = bus.cy;     // JC
      2'b10:   jump_taken_s = ~bus.cy;    // JNC
      default: jump_taken_s = 1'b0;       // 2-byte NOP
    endcase
  end

  // Carry-in follows the live carry so ADC/SBC see the value registered by the
  // previous instruction's EXEC edge.
  always_comb begin
    if (ir_q[2] && ((ir_q[5:3] == 3'b000) || (ir_q[5:3] == 3'b001))) begin
      alu_ci_s = bus.cy;
    end else begin
      alu_ci_s = 1'b0;
    end
  end

  // Sequencer FSM with registered PC, IR, immediate and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= 8'h00;
      ir_q     <= 8'hC0;
      imm_q    <= 8'h00;
      acc_we_q <= 1'b0;
      cy_ce_q  <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle: only the transition into EXEC raises them.
      acc_we_q <= 1'b0;
      cy_ce_q  <= 1'b0;
      case (state_q)
        S_FETCH: begin
          pc_q    <= pc_q + 8'd1;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          ir_q <= bus.prog_data;
          if (dec_halt_s) begin
            halt_q  <= 1'b1;
            state_q <= S_HALT;
          end else if (dec_two_byte_s) begin
            pc_q    <= pc_q + 8'd1;
            state_q <= S_OPERAND;
          end else if (dec_alu_reg_s) begin
            acc_we_q <= 1'b1;
            cy_ce_q  <= dec_cy_ce_s;
            state_q  <= S_EXEC;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_OPERAND: begin
          imm_q <= bus.prog_data;
          if (ir_alu_imm_s) begin
            acc_we_q <= 1'b1;
            cy_ce_q  <= ir_cy_ce_s;
            state_q  <= S_EXEC;
          end else if (jump_taken_s) begin
            state_q <= S_EXEC;
          end else begin
            // PC already points past the operand byte.
            state_q <= S_FETCH;
          end
        end
        S_EXEC: begin
          // Only taken jumps reach EXEC from the jump class.
          if (ir_q[7:6] == 2'b10) begin
            pc_q <= imm_q;
          end else begin
            pc_q <= pc_q;
          end
          state_q <= S_FETCH;
        end
        S_HALT: begin
          halt_q  <= 1'b1;
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.prog_addr = pc_q;
  assign bus.alu_op    = ir_q[5:3];
  assign bus.reg_sel   = ir_q[1:0];
  assign bus.b_sel     = (ir_q[7:6] == 2'b01);
  assign bus.imm       = imm_q;
  assign bus.alu_ci    = alu_ci_s;
  assign bus.acc_we    = acc_we_q;
  assign bus.cy_ce     = cy_ce_q;
  assign bus.halt      = halt_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle fetch/decode/execute controller that drives the 8-bit `alu` and its `CY_reg`. It reads instruction bytes from a synchronous program ROM and decodes each instruction into ALU control signals: operation code, carry-in, B-operand source and register index, immediate value, accumulator write enable and carry-register enable. It also handles conditional and unconditional jumps on the registered carry flag.

## Interface
Parameters: none (fixed 8-bit datapath, 8-bit program address).
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- prog_addr  out  8  program ROM address (= PC register)
- prog_data  in  8  ROM read data, valid the cycle after `prog_addr` is presented
- cy  in  1  registered carry from `CY_reg`
- alu_op  out  3  to `alu.op`
- alu_ci  out  1  to `alu.Ci`
- b_sel  out  1  B-operand mux: 0 = register file, 1 = `imm`
- reg_sel  out  2  register-file index for B
- imm  out  8  latched immediate/operand byte
- acc_we  out  1  accumulator write strobe (one cycle)
- cy_ce  out  1  to `CY_reg.ce` (one cycle)
- halt  out  1  high while halted

## Operation
- Instruction classes, decoded from IR[7:6]:
  - 00 `ooo c rr`: ALU, register operand. op = IR[5:3], c = IR[2], rr = IR[1:0]. 1 byte.
  - 01 `ooo c xx`: ALU, immediate operand. Second byte is `imm`. 2 bytes.
  - 10 `jj xxxx`: jump, second byte is the target. jj = 00 JMP, 01 JC (taken if cy=1), 10 JNC (taken if cy=0), 11 2-byte NOP. 2 bytes.
  - 11: 0xFF = HLT. All other values are 1-byte NOPs.
- The FSM has five states: FETCH, DECODE, OPERAND, EXEC, HALT.
  - FETCH: PC++ → DECODE.
  - DECODE: IR ← prog_data.
    - 2-byte instruction: PC++ → OPERAND.
    - ALU-reg: → EXEC.
    - NOP: → FETCH.
    - 0xFF: → HALT.
  - OPERAND: imm ← prog_data.
    - ALU-imm or taken jump: → EXEC.
    - Not-taken jump or jj=11: → FETCH (PC already points past the operand).
  - EXEC:
    - ALU instruction: acc_we=1; cy_ce=1 if op ≤ 101.
    - Taken jump: PC ← imm.
    - Always → FETCH.
  - HALT: absorbing. Only `rst` leaves it.
- The jump condition is sampled from `cy` in OPERAND.
- Outputs derived from IR, valid from the cycle after DECODE:
  - alu_op = IR[5:3]
  - reg_sel = IR[1:0]
  - b_sel = (IR[7:6] == 01)
- alu_ci = IR[2] & cy when op ∈ {000 ADD, 001 SUB}, else 0. It is combinational on the live `cy`.
- acc_we and cy_ce are asserted only in EXEC, never both outside it.
- PC is 8 bits and wraps 0xFF→0x00. An operand byte at 0xFF is fetched from 0x00.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = FETCH, PC = 0x00, IR = 0xC0 (NOP), imm = 0x00.
  - prog_addr = 0x00, alu_op = 000, alu_ci = 0, b_sel = 0, reg_sel = 00.
  - acc_we = 0, cy_ce = 0, halt = 0.
- The first FETCH occurs in the first clock after `rst` is released.
- Latency in cycles, FETCH to next FETCH:
  - ALU-reg: 3
  - ALU-imm: 4
  - taken jump: 4
  - not-taken jump: 3
  - NOP: 2
- acc_we and cy_ce are high for exactly one cycle, in the last cycle of the instruction. Accumulator and `CY_reg` capture on the same rising edge that leaves EXEC.
- An ADD/SUB with c=1 uses `cy` as registered by the previous instruction's EXEC edge.
- If `rst` is asserted mid-instruction (any state), the instruction is abandoned. No write strobe is issued, and strobes already high drop asynchronously.
- halt rises the cycle after DECODE of 0xFF. prog_addr is then frozen.

## Test plan
- Reset release with ROM[0]=0x00 (ADD r0):
  - prog_addr is 0x00, then 0x01.
  - acc_we=1, cy_ce=1, alu_op=000, b_sel=0 in cycle 3.
- ROM[0]=0x48, ROM[1]=0x05 (SUB imm):
  - In cycle 4: alu_op=001, b_sel=1, imm=0x05, alu_ci=0, acc_we=1, cy_ce=1.
  - Next FETCH at prog_addr=0x02.
- ROM[0]=0x04 (ADD r0 with carry):
  - cy=1 → alu_ci=1 in EXEC.
  - Repeat with cy=0 → alu_ci=0.
- ROM[0]=0x30 (MOV r0), op 110:
  - acc_we=1 and cy_ce=0 in EXEC.
- ROM[0]=0x90, ROM[1]=0x20 (JC 0x20):
  - cy=1 → next FETCH prog_addr=0x20 after 4 cycles.
  - cy=0 → next FETCH at 0x02 after 3 cycles, no strobes.
- Wrap and halt:
  - JMP 0xFF with ROM[0xFF]=0x40 (ADD imm): operand read from 0x00, following FETCH at 0x01.
  - ROM[0x01]=0xFF: halt=1 and held with prog_addr frozen.
  - Pulse rst mid-EXEC elsewhere: acc_we drops immediately and prog_addr returns to 0x00.
